// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle against a
// 1-cycle-latency memory and buffers returned words in a 2-entry FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] fifo_word_q [2];
    logic [31:0] fifo_word_d [2];
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic        wr_ptr;
    logic [2:0]  occupancy;

    assign mem_read_address = fetch_pc_q;
    assign instr_valid      = (count_q != 2'd0);
    assign instr            = fifo_word_q[rd_ptr_q];
    assign instr_pc         = fifo_pc_q[rd_ptr_q];

    always_comb begin
        pop       = instr_valid & instr_ready;
        push      = inflight_q & ~redirect_valid;
        // Slots committed after this cycle; issuing only when <= 1 guarantees
        // the response lands in a free slot next cycle.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = ~redirect_valid & (occupancy <= 3'd1);
        wr_ptr    = rd_ptr_q ^ count_q[0];

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fifo_word_d   = fifo_word_q;
        fifo_pc_d     = fifo_pc_q;

        if (push) begin
            fifo_word_d[wr_ptr] = mem_read_data;
            fifo_pc_d[wr_ptr]   = inflight_pc_q;
        end

        if (redirect_valid) begin
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            count_d    = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d   = rd_ptr_q ^ pop;
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_word_q[i] <= 32'h0;
                fifo_pc_q[i]   <= 32'h0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < 2; i++) begin
                fifo_word_q[i] <= fifo_word_d[i];
                fifo_pc_q[i]   <= fifo_pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle memory model returning
// address XOR 0xA5A5_0000.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] XK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem_read_address ^ XK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return we sit in cycle 0 (first cycle with rst low).
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_data"}, instr, pc ^ XK);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_addr", mem_read_address, RPC);

        // Streaming
        rst = 1'b0;
        check("s_c0_addr", mem_read_address, RPC);
        check("s_c0_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("s_c1_valid", {31'd0, instr_valid}, 32'd0);
        check("s_c1_addr", mem_read_address, 32'h104);
        tick();
        for (int c = 2; c < 8; c++) begin
            check_head("stream", RPC + 32'(4 * (c - 2)));
            tick();
        end

        // Backpressure: ready low through cycle 9
        instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                check_head("bp_hold", 32'h100);
                check("bp_park5", mem_read_address, 32'h108);
            end
            tick();
        end
        check("bp_park10", mem_read_address, 32'h108);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("bp_rel", 32'h100 + 32'(4 * k));
            tick();
        end

        // Redirect with two words buffered
        instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        check("rd_full_valid", {31'd0, instr_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2003;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        check("rd_r1_valid", {31'd0, instr_valid}, 32'd0);
        check("rd_r1_addr", mem_read_address, 32'h2000);
        tick();
        check("rd_r2_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_head("rd_r3", 32'h2000);
        tick();
        check_head("rd_r4", 32'h2004);

        // Redirect with concurrent pop, then back-to-back redirect
        instr_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        check_head("bb_pre", 32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_pc = 32'h400;
        check("bb_r1_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("bb_r2_addr", mem_read_address, 32'h400);
        check("bb_r2_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("bb_r3_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_head("bb_first", 32'h400);
        tick();
        check_head("bb_second", 32'h404);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check_head("wrap0", 32'hFFFF_FFF8);
        tick();
        check_head("wrap1", 32'hFFFF_FFFC);
        tick();
        check_head("wrap2", 32'h0000_0000);

        // Reset with a full FIFO
        instr_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        check("mr_full_valid", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_instr", instr, 32'h0);
        check("mr_pc", instr_pc, 32'h0);
        check("mr_addr", mem_read_address, RPC);
        rst         = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("mr_c1_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_head("mr_c2", RPC);
        tick();
        check_head("mr_c3", RPC + 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
